instruction_fetch: RTL

Instruction fetch stage and IF/ID pipeline register feeding the decode stage. The low 16 bits of if_id_instr drive the sign extender, and that block's 32-bit result returns here as branch_offset for branch-target generation. The block owns the PC, runs a req/ack handshake with instruction memory, and absorbs decode stalls with a one-entry skid buffer. It also applies branch/jump redirects with flush of wrong-path instructions.

---
 rtl/instruction_fetch.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/instruction_fetch.sv
// Instruction fetch stage with IF/ID register, one-entry skid buffer
// and branch/jump redirect handling against a req/ack instruction memory.
module instruction_fetch #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_offset,
  input  logic        jump_en,
  input  logic [25:0] jump_index,
  output logic [31:0] pc,
  output logic        if_id_valid,
  output logic [31:0] if_id_instr,
  output logic [31:0] if_id_pc4
);

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    HOLD,
    DRAIN
  } state_t;

  state_t      state;
  state_t      state_n;
  logic [31:0] pc_n;
  logic        req_n;
  logic [31:0] addr_n;
  logic        valid_n;
  logic [31:0] instr_n;
  logic [31:0] pc4_n;
  logic        skid_valid;
  logic        skid_valid_n;
  logic [31:0] skid_instr;
  logic [31:0] skid_instr_n;
  logic [31:0] skid_pc4;
  logic [31:0] skid_pc4_n;

  logic        ack;
  logic        accept;
  logic        redirect;
  logic [31:0] target;

  assign ack      = imem_req & imem_ack;
  assign accept   = ~stall | ~if_id_valid;
  assign redirect = if_id_valid & (jump_en | branch_taken);

  always_comb begin
    target = if_id_pc4 + (branch_offset << 2);
    if (jump_en) begin
      target = {if_id_pc4[31:28], jump_index, 2'b00};
    end
  end

  always_comb begin
    state_n      = state;
    pc_n         = pc;
    req_n        = imem_req;
    addr_n       = imem_addr;
    // A stalled valid entry holds; otherwise the slot empties unless refilled
    valid_n      = stall & if_id_valid;
    instr_n      = if_id_instr;
    pc4_n        = if_id_pc4;
    skid_valid_n = skid_valid;
    skid_instr_n = skid_instr;
    skid_pc4_n   = skid_pc4;

    unique case (state)
      IDLE: begin
        state_n = FETCH;
        req_n   = 1'b1;
        addr_n  = pc;
      end
      FETCH: begin
        if (ack) begin
          pc_n = pc + 32'd4;
          if (accept) begin
            valid_n = 1'b1;
            instr_n = imem_rdata;
            pc4_n   = imem_addr + 32'd4;
            addr_n  = pc + 32'd4;
          end else begin
            skid_valid_n = 1'b1;
            skid_instr_n = imem_rdata;
            skid_pc4_n   = imem_addr + 32'd4;
            req_n        = 1'b0;
            state_n      = HOLD;
          end
        end
      end
      HOLD: begin
        if (!stall) begin
          valid_n      = skid_valid;
          instr_n      = skid_instr;
          pc4_n        = skid_pc4;
          skid_valid_n = 1'b0;
          req_n        = 1'b1;
          addr_n       = pc;
          state_n      = FETCH;
        end
      end
      DRAIN: begin
        if (ack) begin
          addr_n  = pc;
          state_n = FETCH;
        end
      end
      default: state_n = IDLE;
    endcase

    if (redirect) begin
      pc_n         = target;
      valid_n      = 1'b0;
      instr_n      = NOP_INSTR;
      pc4_n        = if_id_pc4;
      skid_valid_n = 1'b0;
      unique case (state)
        FETCH: begin
          req_n = 1'b1;
          if (ack) begin
            addr_n  = target;
            state_n = FETCH;
          end else begin
            addr_n  = imem_addr;
            state_n = DRAIN;
          end
        end
        HOLD: begin
          req_n   = 1'b1;
          addr_n  = target;
          state_n = FETCH;
        end
        DRAIN: begin
          if (ack) begin
            addr_n  = target;
            state_n = FETCH;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc          <= RESET_PC;
      imem_req    <= 1'b0;
      imem_addr   <= RESET_PC;
      if_id_valid <= 1'b0;
      if_id_instr <= NOP_INSTR;
      if_id_pc4   <= 32'h0;
      skid_valid  <= 1'b0;
      skid_instr  <= NOP_INSTR;
      skid_pc4    <= 32'h0;
    end else begin
      pc          <= pc_n;
      imem_req    <= req_n;
      imem_addr   <= addr_n;
      if_id_valid <= valid_n;
      if_id_instr <= instr_n;
      if_id_pc4   <= pc4_n;
      skid_valid  <= skid_valid_n;
      skid_instr  <= skid_instr_n;
      skid_pc4    <= skid_pc4_n;
    end
  end

endmodule
